// File: rtl/mod_n_counter.sv
// Free-running modulo-NUM up-counter: counts 0..NUM-1 and wraps to 0.
// Supplies the phase/index count for symbol, sample and carrier-table sequencing.
module mod_n_counter #(
    parameter  int NUM = 16,
    localparam int W   = $clog2(NUM - 1)
) (
    input  logic         clk_sig,
    input  logic         reset_sig,
    output logic [W-1:0] counter_sig
);

    // NUM-1 must fit in W bits, so it may not be a power of two.
    if (NUM < 4) begin : g_num_too_small
        $fatal(1, "mod_n_counter: NUM (%0d) must be at least 4", NUM);
    end
    if (((NUM - 1) & (NUM - 2)) == 0) begin : g_num_minus_one_pow2
        $fatal(1, "mod_n_counter: NUM-1 (%0d) must not be a power of two", NUM - 1);
    end

    localparam logic [W-1:0] LAST = W'(NUM - 1);

    // Power-up value lets the counter run even if reset is never asserted.
    logic [W-1:0] count = '0;

    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign counter_sig = count;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter at NUM = 16, 6 and 8.
// Expected values are hand-derived constants or simple modular arithmetic.
`timescale 1ns/1ps
module tb_mod_n_counter;

    logic       clk_sig = 1'b0;
    logic       reset16 = 1'b0;
    logic       reset6  = 1'b0;
    logic       reset8  = 1'b0;
    logic [3:0] cnt16;
    logic [2:0] cnt6;
    logic [2:0] cnt8;

    int checks = 0;
    int errors = 0;

    // 50 ns period, first rising edge at 25 ns.
    always #25 clk_sig = ~clk_sig;

    mod_n_counter #(.NUM(16)) dut16 (.clk_sig(clk_sig), .reset_sig(reset16), .counter_sig(cnt16));
    mod_n_counter #(.NUM(6))  dut6  (.clk_sig(clk_sig), .reset_sig(reset6),  .counter_sig(cnt6));
    mod_n_counter #(.NUM(8))  dut8  (.clk_sig(clk_sig), .reset_sig(reset8),  .counter_sig(cnt8));

    task automatic test_power_up();
        int exp_v;
        #1;
        checks += 3;
        if (cnt16 !== 4'd0) begin errors++; $display("[TB] FAIL power_up16 t0: got %0d expected 0", cnt16); end
        if (cnt6  !== 3'd0) begin errors++; $display("[TB] FAIL power_up6 t0: got %0d expected 0", cnt6); end
        if (cnt8  !== 3'd0) begin errors++; $display("[TB] FAIL power_up8 t0: got %0d expected 0", cnt8); end
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk_sig); #1;
            exp_v = i;
            checks += 3;
            if (cnt16 !== 4'(exp_v)) begin errors++; $display("[TB] FAIL power_up16 edge%0d: got %0d expected %0d", i, cnt16, exp_v); end
            if (cnt6  !== 3'(exp_v)) begin errors++; $display("[TB] FAIL power_up6 edge%0d: got %0d expected %0d", i, cnt6, exp_v); end
            if (cnt8  !== 3'(exp_v)) begin errors++; $display("[TB] FAIL power_up8 edge%0d: got %0d expected %0d", i, cnt8, exp_v); end
        end
    endtask

    task automatic test_reset();
        // Called at t = 76 ns with cnt16 = 2.
        #24;
        reset16 = 1'b1;
        #10;
        checks++;
        if (cnt16 !== 4'd2) begin errors++; $display("[TB] FAIL reset_not_async: got %0d expected 2", cnt16); end
        while ($time < 1600) begin
            @(posedge clk_sig); #1;
            checks++;
            if (cnt16 !== 4'd0) begin errors++; $display("[TB] FAIL reset_held t=%0t: got %0d expected 0", $time, cnt16); end
        end
        #23;
        reset16 = 1'b0;
    endtask

    task automatic test_full_cycle();
        int exp_v;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk_sig); #1;
            exp_v = i % 16;
            checks++;
            if (cnt16 !== 4'(exp_v)) begin errors++; $display("[TB] FAIL full_cycle step%0d: got %0d expected %0d", i, cnt16, exp_v); end
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        // Count is 1 on entry; eight edges bring it to 9.
        repeat (8) @(posedge clk_sig);
        #1;
        checks++;
        if (cnt16 !== 4'd9) begin errors++; $display("[TB] FAIL mid_pre: got %0d expected 9", cnt16); end
        @(negedge clk_sig); reset16 = 1'b1;
        @(posedge clk_sig); #1;
        checks++;
        if (cnt16 !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset: got %0d expected 0", cnt16); end
        @(negedge clk_sig); reset16 = 1'b0;
        @(posedge clk_sig); #1;
        checks++;
        if (cnt16 !== 4'd1) begin errors++; $display("[TB] FAIL mid_release: got %0d expected 1", cnt16); end
        repeat (14) @(posedge clk_sig);
        #1;
        checks++;
        if (cnt16 !== 4'd15) begin errors++; $display("[TB] FAIL wrap_pre: got %0d expected 15", cnt16); end
        @(negedge clk_sig); reset16 = 1'b1;
        @(posedge clk_sig); #1;
        checks++;
        if (cnt16 !== 4'd0) begin errors++; $display("[TB] FAIL wrap_reset: got %0d expected 0", cnt16); end
        @(negedge clk_sig); reset16 = 1'b0;
        @(posedge clk_sig); #1;
        checks++;
        if (cnt16 !== 4'd1) begin errors++; $display("[TB] FAIL wrap_release: got %0d expected 1", cnt16); end
    endtask

    task automatic test_mod6();
        int exp_v;
        @(negedge clk_sig); reset6 = 1'b1;
        @(posedge clk_sig); #1;
        checks++;
        if (cnt6 !== 3'd0) begin errors++; $display("[TB] FAIL mod6_reset: got %0d expected 0", cnt6); end
        @(negedge clk_sig); reset6 = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk_sig); #1;
            exp_v = i % 6;
            checks++;
            if (cnt6 !== 3'(exp_v)) begin errors++; $display("[TB] FAIL mod6 step%0d: got %0d expected %0d", i, cnt6, exp_v); end
        end
    endtask

    task automatic test_mod8();
        int exp_v;
        @(negedge clk_sig); reset8 = 1'b1;
        @(posedge clk_sig); #1;
        checks++;
        if (cnt8 !== 3'd0) begin errors++; $display("[TB] FAIL mod8_reset: got %0d expected 0", cnt8); end
        @(negedge clk_sig); reset8 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk_sig); #1;
            exp_v = i % 8;
            checks++;
            if (cnt8 !== 3'(exp_v)) begin errors++; $display("[TB] FAIL mod8 step%0d: got %0d expected %0d", i, cnt8, exp_v); end
        end
    endtask

    initial begin
        test_power_up();
        test_reset();
        test_full_cycle();
        test_reset_mid_and_wrap();
        test_mod6();
        test_mod8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
